// File: rtl/gf163_digit_serial_mul_if.sv
// Start/done handshake and operand/result bus for the GF(2^163) digit-serial multiplier.
// Optional accumulate operands exist only when GF163_MUL_ACC_EN is defined.
interface gf163_digit_serial_mul_if #(
    parameter int M = 163
);
    logic         start;
    logic [M-1:0] a_in;
    logic [M-1:0] b_in;
    logic         busy;
    logic         done;
    logic [M-1:0] c_out;
`ifdef GF163_MUL_ACC_EN
    logic [M-1:0] acc_in;
    logic         acc_en;

    modport master (output start, a_in, b_in, acc_in, acc_en, input busy, done, c_out);
    modport slave  (input start, a_in, b_in, acc_in, acc_en, output busy, done, c_out);
`else
    modport master (output start, a_in, b_in, input busy, done, c_out);
    modport slave  (input start, a_in, b_in, output busy, done, c_out);
`endif
endinterface

// File: rtl/gf163_digit_serial_mul.sv
// MSB-first digit-serial multiplier over GF(2^163), f = x^163 + x^7 + x^6 + x^3 + 1, 8 bits/clock.
// Define GF163_MUL_ACC_EN to add acc_in/acc_en and produce a*b + c.
module gf163_digit_serial_mul (
    input  logic                          clk,
    input  logic                          rst_n,
    gf163_digit_serial_mul_if.slave       bus
);
    localparam int M    = 163;
    localparam int D    = 8;
    localparam int NDIG = 21;
    localparam int BW   = NDIG * D;
    localparam logic [M-1:0] POLY     = 163'hC9;
    localparam logic [4:0]   CNT_LAST = 5'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [4:0]     cnt;
    logic [M-1:0]   a_reg;
    logic [BW-1:0]  b_reg;
    logic [M-1:0]   t_reg;
    logic [M-1:0]   c_reg;
    logic [M-1:0]   t_step;
    logic [M-1:0]   acc_term;
    logic [D-1:0]   digit;
    logic           accept;

`ifdef GF163_MUL_ACC_EN
    logic [M-1:0]   acc_reg;
    assign acc_term = acc_reg;
`else
    assign acc_term = '0;
`endif

    // Next state and acceptance; start only counts outside RUN.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // D chained shift/reduce/add steps, leading bit of the digit first.
    always_comb begin
        digit  = b_reg[cnt*D +: D];
        t_step = t_reg;
        for (int unsigned k = 0; k < D; k++) begin
            t_step = {t_step[M-2:0], 1'b0}
                   ^ (t_step[M-1] ? POLY : '0)
                   ^ (digit[D-1-k] ? a_reg : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            t_reg <= '0;
            c_reg <= '0;
`ifdef GF163_MUL_ACC_EN
            acc_reg <= '0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                a_reg <= bus.a_in;
                b_reg <= {{(BW-M){1'b0}}, bus.b_in};
                t_reg <= '0;
                cnt   <= CNT_LAST;
`ifdef GF163_MUL_ACC_EN
                acc_reg <= bus.acc_en ? bus.acc_in : '0;
`endif
            end else if (state == RUN) begin
                t_reg <= t_step;
                cnt   <= cnt - 1'b1;
                if (cnt == '0) c_reg <= t_step ^ acc_term;
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.c_out = c_reg;

endmodule

// File: tb/tb_gf163_digit_serial_mul.sv
// Randomized self-checking bench for gf163_digit_serial_mul against a schoolbook
// carry-less multiply followed by polynomial long-division reduction.
module tb_gf163_digit_serial_mul;
    localparam int M = 163;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gf163_digit_serial_mul_if #(.M(M)) bus ();

    gf163_digit_serial_mul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] p;
        logic [2*M-2:0] f;
        p = '0;
        f = '0;
        f[M] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        for (int i = 0; i < M; i++)
            if (b[i]) p ^= ({{(M-1){1'b0}}, a} << i);
        for (int i = 2*M-2; i >= M; i--)
            if (p[i]) p ^= (f << (i - M));
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rnd163();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[M-1:0];
    endfunction

    // Drive a request at the current point (just after an edge) and let the next edge take it.
    task automatic issue(input logic [M-1:0] a, input logic [M-1:0] b);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Called just after the acceptance edge; returns at the first sample with done high.
    task automatic wait_done(input logic [M-1:0] prev_c, input bit noise, output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (edges < 40) begin
            if (noise) begin
                bus.start = 1'b1;
                bus.a_in  = rnd163();
                bus.b_in  = rnd163();
            end
            @(posedge clk); #1;
            edges++;
            if (edges == 10) check("hold", bus.c_out, prev_c);
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
        if (!bus.done) check("timeout", {{(M-1){1'b0}}, bus.done}, {{(M-1){1'b0}}, 1'b1});
    endtask

    task automatic run_op(input string tag, input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] exp);
        int edges;
        int busy_cnt;
        logic [M-1:0] prev;
        prev = bus.c_out;
        issue(a, b);
        wait_done(prev, 1'b0, edges, busy_cnt);
        check({tag, "_lat"},  M'(edges), M'(21));
        check({tag, "_busy"}, M'(busy_cnt), M'(21));
        check(tag, bus.c_out, exp);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {{(M-1){1'b0}}, bus.done}, '0);
    endtask

    initial begin
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] x162;
        int edges;
        int busy_cnt;
        total = 0;
        bad   = 0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
`ifdef GF163_MUL_ACC_EN
        bus.acc_in = '0;
        bus.acc_en = 1'b0;
`endif
        x162 = '0;
        x162[162] = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {{(M-1){1'b0}}, bus.busy}, '0);
        check("rst_done", {{(M-1){1'b0}}, bus.done}, '0);
        check("rst_c", bus.c_out, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("one", M'(1), M'(1), M'(1));
        run_op("wrap", x162, M'(2), 163'hC9);
        check("model_wrap", gf_mul(x162, M'(2)), 163'hC9);
        a = rnd163() | M'(1);
        run_op("b_zero", a, '0, '0);
        run_op("a_zero", '0, a, '0);
        run_op("msb_sq", x162, x162, gf_mul(x162, x162));

        for (int n = 0; n < 8; n++) begin
            a = rnd163();
            b = rnd163();
            run_op("rand", a, b, gf_mul(a, b));
        end

        // start held with junk during RUN, then a back-to-back launch from DONE
        a = bus.c_out;
        issue(M'(3), M'(5));
        wait_done(a, 1'b1, edges, busy_cnt);
        check("noise_lat", M'(edges), M'(21));
        check("noise_c", bus.c_out, 163'hF);
        a = rnd163();
        b = rnd163();
        issue(a, b);
        check("b2b_busy", {{(M-1){1'b0}}, bus.busy}, {{(M-1){1'b0}}, 1'b1});
        wait_done(163'hF, 1'b0, edges, busy_cnt);
        check("b2b_lat", M'(edges), M'(21));
        check("b2b_c", bus.c_out, gf_mul(a, b));

        // asynchronous reset mid-RUN
        @(posedge clk); #1;
        issue(x162, M'(2));
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {{(M-1){1'b0}}, bus.busy}, '0);
        check("arst_done", {{(M-1){1'b0}}, bus.done}, '0);
        check("arst_c", bus.c_out, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle", {{(M-1){1'b0}}, bus.busy}, '0);
        run_op("post_rst", M'(1), M'(1), M'(1));

`ifdef GF163_MUL_ACC_EN
        bus.acc_in = M'(3);
        bus.acc_en = 1'b1;
        run_op("acc_on", M'(1), M'(1), M'(2));
        bus.acc_en = 1'b0;
        run_op("acc_off", M'(1), M'(1), M'(1));
        for (int n = 0; n < 3; n++) begin
            a = rnd163();
            b = rnd163();
            bus.acc_in = rnd163();
            bus.acc_en = 1'b1;
            run_op("acc_rand", a, b, gf_mul(a, b) ^ bus.acc_in);
        end
        bus.acc_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule
